// File: rtl/cache_pkg.sv
// Shared types and geometry helpers for the N-way set-associative data cache.
// The addr_mode encodings match the load/store unit's DATA_ADDR_MODE_* codes.
package cache_pkg;

  localparam int LINE_BYTES   = 4;
  localparam int MAX_TAG_BITS = 32;

  localparam logic [2:0] ADDR_MODE_B  = 3'b000;
  localparam logic [2:0] ADDR_MODE_H  = 3'b001;
  localparam logic [2:0] ADDR_MODE_W  = 3'b010;
  localparam logic [2:0] ADDR_MODE_BU = 3'b100;
  localparam logic [2:0] ADDR_MODE_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT} state_t;

  // Tags are stored zero-extended so that one line type serves every geometry.
  typedef struct packed {
    logic                           valid;
    logic [MAX_TAG_BITS-1:0]        tag;
    logic [LINE_BYTES-1:0][7:0]     data;
  } cache_line_t;

  function automatic int set_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int num_sets);
    return addr_width - 2 - $clog2(num_sets);
  endfunction

endpackage

// File: rtl/lru_ages.sv
// True-LRU age tracker for one set; ages always form a permutation of 0..NUM_WAYS-1,
// with 0 the most recently used way.
module lru_ages #(
  parameter  int NUM_WAYS = 4,
  localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               init,
  input  logic                               touch,
  input  logic [WAY_BITS-1:0]                touch_way,
  output logic [NUM_WAYS-1:0][WAY_BITS-1:0]  ages,
  output logic [WAY_BITS-1:0]                lru_way
);

  always_ff @(posedge clk) begin
    if (!rst_n || init) begin
      for (int w = 0; w < NUM_WAYS; w++) ages[w] <= WAY_BITS'(w);
    end else if (touch) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (WAY_BITS'(w) == touch_way)
          ages[w] <= '0;
        else if (ages[w] < ages[touch_way])
          ages[w] <= ages[w] + WAY_BITS'(1);
      end
    end
  end

  always_comb begin
    lru_way = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (ages[w] == WAY_BITS'(NUM_WAYS - 1)) lru_way = WAY_BITS'(w);
  end

endmodule

// File: rtl/nway_cache.sv
// Write-through, write-around N-way set-associative data cache, one word per line,
// with a stalling memory handshake, single-cycle flush and hit/miss counters.
module nway_cache
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WAYS   = 4,
  parameter int NUM_SETS   = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            addr_mode,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  hit,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_addr_mode,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  localparam int WAY_BITS = $clog2(NUM_WAYS);
  localparam int SET_BITS = set_bits(NUM_SETS);
  localparam int TAG_BITS = tag_bits(ADDR_WIDTH, NUM_SETS);

  state_t                               state;
  cache_line_t                          lines [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0][WAY_BITS-1:0]    set_ages [NUM_SETS];
  logic [WAY_BITS-1:0]                  set_lru [NUM_SETS];

  logic [SET_BITS-1:0]     cpu_set, mem_set, touch_set;
  logic [MAX_TAG_BITS-1:0] cpu_tag, mem_tag;
  logic [WAY_BITS-1:0]     hit_way, victim, wr_way, touch_way;
  logic                    lookup_hit, wr_hit, touch_any, touch_live;
  logic                    idle_flush, idle_write, idle_read, rd_done, wr_done;
  logic [3:0][7:0]         wr_data;

  assign cpu_set = addr[2 +: SET_BITS];
  assign mem_set = mem_addr[2 +: SET_BITS];
  assign cpu_tag = MAX_TAG_BITS'(addr[ADDR_WIDTH-1 -: TAG_BITS]);
  assign mem_tag = MAX_TAG_BITS'(mem_addr[ADDR_WIDTH-1 -: TAG_BITS]);

  always_comb begin
    lookup_hit = 1'b0;
    hit_way    = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (lines[cpu_set][w].valid && lines[cpu_set][w].tag == cpu_tag) begin
        lookup_hit = 1'b1;
        hit_way    = WAY_BITS'(w);
      end
    end
  end

  // Fill the lowest-index invalid way first, otherwise the least recently used one.
  always_comb begin
    victim = set_lru[mem_set];
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!lines[mem_set][w].valid) victim = WAY_BITS'(w);
  end

  assign hit        = (read_en | write_en) & lookup_hit;
  assign idle_flush = (state == IDLE) && flush;
  assign idle_write = (state == IDLE) && !flush && write_en;
  assign idle_read  = (state == IDLE) && !flush && !write_en && read_en;
  assign rd_done    = (state == RD_WAIT) && mem_ready;
  assign wr_done    = (state == WR_WAIT) && mem_ready;
  assign mem_req    = (state != IDLE);
  assign mem_we     = (state == WR_WAIT);

  always_comb begin
    if (state == IDLE) stall = idle_write || (idle_read && !lookup_hit);
    else               stall = !mem_ready;
  end

  always_comb begin
    if (idle_read && lookup_hit) out = lines[cpu_set][hit_way].data;
    else if (rd_done)            out = mem_rdata;
    else                         out = '0;
  end

  always_comb begin
    touch_any = 1'b0;
    touch_set = cpu_set;
    touch_way = hit_way;
    if (idle_read && lookup_hit) begin
      touch_any = 1'b1;
    end else if (rd_done) begin
      touch_any = 1'b1;
      touch_set = mem_set;
      touch_way = victim;
    end else if (wr_done && wr_hit) begin
      touch_any = 1'b1;
      touch_set = mem_set;
      touch_way = wr_way;
    end
  end

  // Touching the way that is already most recent changes nothing, so skip it.
  assign touch_live = touch_any && (set_ages[touch_set][touch_way] != '0);

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    lru_ages #(.NUM_WAYS(NUM_WAYS)) u_lru (
      .clk       (clk),
      .rst_n     (rst_n),
      .init      (idle_flush),
      .touch     (touch_live && (touch_set == SET_BITS'(s))),
      .touch_way (touch_way),
      .ages      (set_ages[s]),
      .lru_way   (set_lru[s])
    );
  end

  always_comb begin
    wr_data = lines[mem_set][wr_way].data;
    case (mem_addr_mode)
      ADDR_MODE_B, ADDR_MODE_BU: wr_data[mem_addr[1:0]] = mem_wdata[7:0];
      ADDR_MODE_H, ADDR_MODE_HU: begin
        wr_data[{mem_addr[1], 1'b0}] = mem_wdata[7:0];
        wr_data[{mem_addr[1], 1'b1}] = mem_wdata[15:8];
      end
      default: wr_data = mem_wdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || idle_flush) begin
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) lines[s][w].valid <= 1'b0;
    end else if (rd_done) begin
      lines[mem_set][victim] <= '{1'b1, mem_tag, mem_rdata};
    end else if (wr_done && wr_hit) begin
      lines[mem_set][wr_way].data <= wr_data;
    end
  end

  // Hit/way are captured at entry so a store completes against the line it looked up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem_addr      <= '0;
      mem_addr_mode <= '0;
      mem_wdata     <= '0;
      wr_hit        <= 1'b0;
      wr_way        <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (idle_write || (idle_read && !lookup_hit)) begin
            mem_addr      <= addr;
            mem_addr_mode <= addr_mode;
            mem_wdata     <= write_data;
            wr_hit        <= lookup_hit;
            wr_way        <= hit_way;
            state         <= idle_write ? WR_WAIT : RD_WAIT;
          end else if (idle_read) begin
            hit_count <= hit_count + CNT_WIDTH'(1);
          end
        end
        RD_WAIT: begin
          if (mem_ready) begin
            miss_count <= miss_count + CNT_WIDTH'(1);
            state      <= IDLE;
          end
        end
        WR_WAIT: begin
          if (mem_ready) begin
            if (wr_hit) hit_count  <= hit_count + CNT_WIDTH'(1);
            else        miss_count <= miss_count + CNT_WIDTH'(1);
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nway_cache.md
Name: nway_cache

Overview:
- Parametrised N-way set-associative, write-through data cache between the load/store unit and data memory.
- Replaces the fixed 2-way cache. Adds:
  - configurable ways and sets
  - true-LRU replacement
  - multi-cycle memory handshake with a CPU stall
  - write-around on write miss
  - single-cycle flush
  - hit/miss performance counters
- One word per line.

Parameters:
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, word width; fixed 4 bytes per line
- NUM_WAYS, 4, associativity; power of two, 2..8
- NUM_SETS, 8, sets; power of two, 2..256
- CNT_WIDTH, 32, width of each performance counter

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- addr_mode  in  3  `DATA_ADDR_MODE_*` code from def.sv
- addr  in  ADDR_WIDTH  byte address
- write_data  in  DATA_WIDTH  store data, right-aligned
- read_en  in  1  load request
- write_en  in  1  store request
- flush  in  1  invalidate all lines
- out  out  DATA_WIDTH  aligned word for a load; formatting is done downstream
- hit  out  1  lookup hit, combinational
- stall  out  1  CPU must hold addr, addr_mode, write_data, read_en and write_en stable while high
- mem_req  out  1  memory request valid
- mem_we  out  1  memory request is a write
- mem_addr  out  ADDR_WIDTH  registered copy of addr
- mem_addr_mode  out  3  registered copy of addr_mode
- mem_wdata  out  DATA_WIDTH  registered copy of write_data
- mem_ready  in  1  memory completes the request this cycle; mem_rdata valid on a read
- mem_rdata  in  DATA_WIDTH  full aligned word
- hit_count  out  CNT_WIDTH  completed read and write hits
- miss_count  out  CNT_WIDTH  completed read and write misses

Behaviour:
- Address split: offset = addr[1:0]; set = addr[2 +: log2(NUM_SETS)]; tag = remaining upper bits.
- Line contents: valid, tag, 4 bytes. Each set also holds a log2(NUM_WAYS)-bit age per way. Ages in a set are always a permutation of 0..NUM_WAYS-1; 0 is most recent.
- hit = (read_en | write_en) & any way in the set is valid with a matching tag. Exactly one way may match.
- Victim: lowest-index invalid way; if none, the way with age NUM_WAYS-1.
- LRU touch of way w: every way with age < age[w] increments; age[w] <= 0.
- States: IDLE, RD_WAIT, WR_WAIT.
- IDLE, priority order:
  - flush: clear all valid bits, reset ages to age[w] = w. Takes 1 cycle; no stall.
  - write_en (wins over read_en):
    - latch the mem_* registers, go to WR_WAIT.
    - stall = 1 combinationally.
  - read_en with hit:
    - out = hit way data; stall = 0; zero-latency.
    - touch LRU; hit_count++.
  - read_en with miss:
    - stall = 1; latch the mem_* registers; go to RD_WAIT.
- RD_WAIT:
  - mem_req = 1, mem_we = 0.
  - On mem_ready: out = mem_rdata and stall = 0 in that cycle. At the edge, fill the victim (valid = 1, tag, data), touch it, miss_count++, go to IDLE.
- WR_WAIT:
  - mem_req = 1, mem_we = 1.
  - On mem_ready: stall = 0. At the edge, if the latched address hit at entry:
    - update the hit way's bytes per addr_mode (B/BU: byte[offset]; H/HU: bytes[2*offset[1] +: 2]; W: all 4).
    - touch LRU; hit_count++.
  - Otherwise miss_count++ with no allocation (write-around, so there are no partial-line fills). Go to IDLE.
- Outside IDLE, stall = !mem_ready; flush is ignored (the requester holds it); new requests are not sampled.
- mem_req stays high until mem_ready is sampled. mem_* registers are constant for the whole transaction.
- Counters wrap modulo 2^CNT_WIDTH. flush does not clear them.
- Reset (rst_n = 0 at an edge), including mid-transaction:
  - state returns to IDLE; mem_req = 0, stall = 0.
  - all valid bits = 0; ages set to age[w] = w.
  - counters = 0; mem_* registers = 0; out = 0.
  - The abandoned memory transaction is not retried; counters are not updated.
- out = 0 when no load is being returned.

Decomposition:
- Package cache_pkg:
  - cache_line_t struct (valid, tag, 4 byte fields)
  - state enum {IDLE, RD_WAIT, WR_WAIT}
  - localparam helpers SET_BITS and TAG_BITS derived from the parameters.
- Sub-module lru_ages, instantiated once per set:
  - inputs: touch, touch_way, init
  - outputs: ages vector, lru_way
  - owns the permutation invariant.

Test Plan:
1. NUM_WAYS=4, NUM_SETS=8: load 0x0000_0100 (miss, mem_rdata = 0xDEADBEEF, mem_ready after 3 cycles) → stall high 3 cycles, out = 0xDEADBEEF on the ready cycle. Second load of the same address → hit = 1, stall = 0, out = 0xDEADBEEF, hit_count = 1, miss_count = 1.
2. Load 5 distinct tags into set 0 (0x000, 0x020, 0x040, 0x060, 0x080), then reload 0x000 → fifth fill evicts 0x000 (miss). Reloading 0x020 after touching it before the fifth fill → hit.
3. Store byte (B mode, value 0x55) to 0x103 after scenario 1 → mem_we = 1 transaction; then load 0x100 → hit, out = 0x55ADBEEF.
4. Store word to uncached 0x0000_0200 → memory write occurs, miss_count increments; then load 0x200 → miss (no allocation).
5. Flush in IDLE after fills → next load of 0x100 misses; hit_count unchanged.
6. Assert rst_n = 0 during RD_WAIT → next cycle mem_req = 0, stall = 0, all loads miss, counters = 0.
